card_shoe: RTL and testbench
============================

// Module: card_shoe
// PURPOSE
//   Multi-deck baccarat card shoe; upstream card source for the round FSM and scoring datapath.
//   Deals one card per request without replacement, tracks per-rank counts, reshuffles on demand or when empty.
//   Replaces the free-running rank counter so cards are never dealt more than the deck holds.
// PARAMETERS
//   NUM_DECKS  8        decks in shoe; each rank starts at 4*NUM_DECKS
//   CUT_LEFT   16       shoe_low asserts when cards_left < CUT_LEFT
//   LFSR_SEED  16'hACE1 LFSR reset value; must be nonzero
// PORTS
//   clock       in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   deal_req    in   1   request one card; sampled only in IDLE
//   shuffle_req in   1   request reshuffle; sampled only in IDLE
//   card_valid  out  1   one-cycle pulse; new_card valid this cycle
//   new_card    out  4   1=A,2..10,11=J,12=Q,13=K; holds last dealt card
//   cards_left  out  CW  cards remaining; CW=$clog2(52*NUM_DECKS+1)
//   shoe_low    out  1   cards_left < CUT_LEFT (combinational from register)
//   busy        out  1   state != IDLE
// BEHAVIOUR
//   Reset (async): state=IDLE, all 13 counts=4*NUM_DECKS, cards_left=52*NUM_DECKS,
//     new_card=0, card_valid=0, lfsr=LFSR_SEED, seq_ptr=1, pend_deal=0. Reset mid-deal/shuffle aborts it at once.
//   LFSR: 16-bit Galois, mask 16'hB400, advances every clock incl. IDLE.
//   Pick rank: r=lfsr[3:0]; if r>12 then r=r-13; rank=r+1 (1..13).
//   States: IDLE, SCAN, SHUFFLE.
//   IDLE: shuffle_req=1 -> SHUFFLE (deal_req same cycle dropped, no card).
//     else deal_req=1 and cards_left=0 -> SHUFFLE, pend_deal=1.
//     else deal_req=1 -> SCAN, latch pick rank into cur.
//   SCAN (one rank checked per cycle): count[cur]!=0 -> count[cur]-=1, cards_left-=1,
//     new_card=cur, card_valid=1 next cycle, -> IDLE. Else cur=(cur==13)?1:cur+1, stay.
//     Max 13 SCAN cycles; cards_left>0 guarantees a hit.
//   Latency: deal_req sampled at edge k -> card_valid high after edge k+1+misses.
//   SHUFFLE: 13 cycles, one rank count reloaded per cycle (rank 1..13 in order);
//     on last cycle cards_left=52*NUM_DECKS; pend_deal=1 -> SCAN (pick rank latched, pend_deal=0), else IDLE.
//   Requests outside IDLE are ignored; requests are levels, no queueing.
//   card_valid is never high two consecutive cycles; back-to-back deals need deal_req held or re-asserted in IDLE.
//   Arithmetic: counts 4*NUM_DECKS max, width $clog2(4*NUM_DECKS+1); no underflow (guarded by !=0).
// CONFIGURATION
//   SHOE_SEQ_DEAL_EN defined: pick rank = seq_ptr instead of LFSR; seq_ptr advances 1..13 wrap
//     after every dealt card; deterministic order for bench/board debug. LFSR still present, unused.
//   Undefined (default): LFSR pick as above; seq_ptr logic not synthesised.
// TESTING
//   Reset: assert reset -> cards_left=416, busy=0, card_valid=0, new_card=0, shoe_low=0.
//   SHOE_SEQ_DEAL_EN, NUM_DECKS=1: 13 deals -> new_card 1,2,..,13; each card_valid 2 clocks after req; cards_left=39.
//   LFSR mode, NUM_DECKS=1: 52 deals -> each rank exactly 4 times, cards_left=0, shoe_low=1; 53rd deal_req ->
//     busy 13 SHUFFLE cycles + 1 SCAN, card_valid once, cards_left=51.
//   deal_req and shuffle_req same IDLE cycle -> 13 busy cycles, no card_valid, cards_left=52*NUM_DECKS.
//   Mid-shoe shuffle_req after 10 deals -> cards_left restored to full, later histogram of 52 deals = 4 per rank.
//   reset asserted during SCAN/SHUFFLE -> outputs at reset values same cycle, no card_valid after release.

Source files
------------

// File: rtl/card_shoe.sv
`default_nettype none
// card_shoe: multi-deck shoe dealing one rank per request without replacement, with reshuffle.
// Optional macro SHOE_SEQ_DEAL_EN: pick rank from a 1..13 sequence pointer instead of the LFSR.
module card_shoe #(
  parameter int          NUM_DECKS = 8,
  parameter int          CUT_LEFT  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CW        = $clog2(52*NUM_DECKS+1),
  localparam int         NW        = $clog2(4*NUM_DECKS+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          deal_req,
  input  logic          shuffle_req,
  output logic          card_valid,
  output logic [3:0]    new_card,
  output logic [CW-1:0] cards_left,
  output logic          shoe_low,
  output logic          busy
);

  localparam logic [CW-1:0] c_full_cards = CW'(52*NUM_DECKS);
  localparam logic [NW-1:0] c_rank_full  = NW'(4*NUM_DECKS);
  localparam logic [15:0]   c_lfsr_mask  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_SHUFFLE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [NW-1:0]   r_count [1:13];
  logic [CW-1:0]   r_left;
  logic [3:0]      r_new_card;
  logic            r_card_valid;
  logic [15:0]     r_lfsr;
  logic [3:0]      r_cur;
  logic [3:0]      r_shuf_idx;
  logic            r_pend;

  logic [15:0]     w_lfsr_next;
  logic [3:0]      w_pick;
  logic            w_hit;
  logic            w_load_cur;
  logic            w_deal;
  logic            w_go_shuf;
  logic            w_set_pend;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_mask) : (r_lfsr >> 1);

`ifdef SHOE_SEQ_DEAL_EN
  logic [3:0] r_seq_ptr;

  assign w_pick = r_seq_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seq_ptr <= 4'd1;
    end else if (w_deal) begin
      r_seq_ptr <= (r_seq_ptr == 4'd13) ? 4'd1 : r_seq_ptr + 4'd1;
    end
  end
`else
  logic [3:0] w_lfsr_nib;

  // Fold 13..15 back onto 0..2, then shift to rank 1..13.
  assign w_lfsr_nib = r_lfsr[3:0];
  assign w_pick     = (w_lfsr_nib > 4'd12) ? (w_lfsr_nib - 4'd12) : (w_lfsr_nib + 4'd1);
`endif

  assign w_hit = (r_count[r_cur] != '0);

  always_comb begin
    w_state_next = r_state;
    w_load_cur   = 1'b0;
    w_deal       = 1'b0;
    w_go_shuf    = 1'b0;
    w_set_pend   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (shuffle_req) begin
          w_state_next = S_SHUFFLE;
          w_go_shuf    = 1'b1;
        end else if (deal_req) begin
          if (r_left == '0) begin
            w_state_next = S_SHUFFLE;
            w_go_shuf    = 1'b1;
            w_set_pend   = 1'b1;
          end else begin
            w_state_next = S_SCAN;
            w_load_cur   = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_state_next = S_IDLE;
          w_deal       = 1'b1;
        end
      end
      S_SHUFFLE: begin
        if (r_shuf_idx == 4'd13) begin
          if (r_pend) begin
            w_state_next = S_SCAN;
            w_load_cur   = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 13; i++) begin
        r_count[i] <= c_rank_full;
      end
      r_left       <= c_full_cards;
      r_new_card   <= 4'd0;
      r_card_valid <= 1'b0;
      r_lfsr       <= LFSR_SEED;
      r_cur        <= 4'd1;
      r_shuf_idx   <= 4'd1;
      r_pend       <= 1'b0;
    end else begin
      r_lfsr       <= w_lfsr_next;
      r_card_valid <= w_deal;

      if (w_load_cur) begin
        r_cur <= w_pick;
      end else if ((r_state == S_SCAN) && !w_hit) begin
        r_cur <= (r_cur == 4'd13) ? 4'd1 : r_cur + 4'd1;
      end

      if (w_deal) begin
        r_count[r_cur] <= r_count[r_cur] - NW'(1);
        r_left         <= r_left - CW'(1);
        r_new_card     <= r_cur;
      end

      if (w_go_shuf) begin
        r_shuf_idx <= 4'd1;
        r_pend     <= w_set_pend;
      end

      // One rank reloaded per cycle; the full total lands with the last rank.
      if (r_state == S_SHUFFLE) begin
        r_count[r_shuf_idx] <= c_rank_full;
        r_shuf_idx          <= r_shuf_idx + 4'd1;
        if (r_shuf_idx == 4'd13) begin
          r_left <= c_full_cards;
          r_pend <= 1'b0;
        end
      end
    end
  end

  assign card_valid = r_card_valid;
  assign new_card   = r_new_card;
  assign cards_left = r_left;
  assign shoe_low   = (int'(r_left) < CUT_LEFT);
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// tb_card_shoe: randomized deals against a rank-count model, checked through a card scoreboard.
module tb_card_shoe;

  localparam int          ND   = 1;
  localparam int          CUT  = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          CW   = $clog2(52*ND+1);
  localparam int          FULL = 52*ND;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          deal_req = 1'b0;
  logic          shuffle_req = 1'b0;
  logic          card_valid;
  logic [3:0]    new_card;
  logic [CW-1:0] cards_left;
  logic          shoe_low;
  logic          busy;

  card_shoe #(.NUM_DECKS(ND), .CUT_LEFT(CUT), .LFSR_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .deal_req(deal_req), .shuffle_req(shuffle_req),
    .card_valid(card_valid), .new_card(new_card), .cards_left(cards_left),
    .shoe_low(shoe_low), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {int card; int due; int left;} exp_t;
  exp_t        q[$];
  int          m_cnt[1:13];
  int          m_left;
  int          m_seq;
  int          hist[16];
  logic [15:0] m_lfsr;
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          prev_valid = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Free-running model of the shoe's random source, one step per clock.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr <= SEED;
      cyc    <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      cyc    <= cyc + 1;
    end
  end

  // Monitor: every card_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (card_valid) begin
        chk(!prev_valid, "valid_not_consecutive", int'(prev_valid), 0);
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_card", int'(new_card), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(int'(new_card) == e.card, "card_rank", int'(new_card), e.card);
          chk(cyc == e.due, "card_latency_cycle", cyc, e.due);
          chk(int'(cards_left) == e.left, "cards_left_after_deal", int'(cards_left), e.left);
          hist[new_card]++;
        end
      end
      prev_valid = card_valid;
    end
  end

  task automatic model_full();
    for (int i = 1; i <= 13; i++) m_cnt[i] = 4*ND;
    m_left = FULL;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) hist[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_deal();
    logic [15:0] l;
    int          r;
    int          lat;
    int          n;
    exp_t        e;
    l   = m_lfsr;
    lat = 1;
    if (m_left == 0) begin
      for (int i = 0; i < 13; i++) l = lfsr_step(l);
      lat = 14;
      model_full();
    end
`ifdef SHOE_SEQ_DEAL_EN
    r = m_seq;
`else
    r = int'(l[3:0]);
    if (r > 12) r = r - 13;
    r = r + 1;
`endif
    while (m_cnt[r] == 0) begin
      r = (r == 13) ? 1 : r + 1;
      lat++;
    end
    m_cnt[r]--;
    m_left--;
    m_seq  = (m_seq == 13) ? 1 : m_seq + 1;
    e.card = r;
    e.due  = cyc + 1 + lat;
    e.left = m_left;
    q.push_back(e);
    deal_req = 1'b1;
    @(negedge clock);
    deal_req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) chk(1'b0, "deal_timeout", n, 40);
    chk(shoe_low == (m_left < CUT), "shoe_low_track", int'(shoe_low), int'(m_left < CUT));
    idle($urandom_range(0, 2));
  endtask

  task automatic do_shuffle(input bit with_deal);
    int n;
    shuffle_req = 1'b1;
    deal_req    = with_deal;
    @(negedge clock);
    shuffle_req = 1'b0;
    deal_req    = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk(n == 13, "shuffle_busy_cycles", n, 13);
    model_full();
    chk(int'(cards_left) == FULL, "cards_left_after_shuffle", int'(cards_left), FULL);
  endtask

  task automatic check_hist(input string name);
    idle(1);
    for (int i = 1; i <= 13; i++) chk(hist[i] == 4*ND, name, hist[i], 4*ND);
  endtask

  task automatic reset_abort(input bit in_shuffle, input int hold);
    if (in_shuffle) shuffle_req = 1'b1;
    else            deal_req    = 1'b1;
    @(negedge clock);
    shuffle_req = 1'b0;
    deal_req    = 1'b0;
    idle(hold);
    reset = 1'b1;
    #1;
    chk(int'(cards_left) == FULL, "abort_cards_left", int'(cards_left), FULL);
    chk(busy == 1'b0, "abort_busy", int'(busy), 0);
    chk(card_valid == 1'b0, "abort_card_valid", int'(card_valid), 0);
    chk(new_card == 4'd0, "abort_new_card", int'(new_card), 0);
    q.delete();
    model_full();
    m_seq = 1;
    idle(2);
    reset = 1'b0;
    idle(20);
  endtask

  initial begin
    model_full();
    m_seq = 1;
    clear_hist();
    idle(3);
    chk(int'(cards_left) == FULL, "reset_cards_left", int'(cards_left), FULL);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(card_valid == 1'b0, "reset_card_valid", int'(card_valid), 0);
    chk(new_card == 4'd0, "reset_new_card", int'(new_card), 0);
    chk(shoe_low == 1'b0, "reset_shoe_low", int'(shoe_low), 0);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < FULL; i++) do_deal();
    check_hist("hist_full_shoe");
    chk(int'(cards_left) == 0, "empty_cards_left", int'(cards_left), 0);
    chk(shoe_low == 1'b1, "empty_shoe_low", int'(shoe_low), 1);

    do_deal();
    idle(1);
    chk(int'(cards_left) == FULL - 1, "auto_reshuffle_left", int'(cards_left), FULL - 1);

    do_shuffle(1'b1);
    idle(3);

    clear_hist();
    for (int i = 0; i < 10; i++) do_deal();
    do_shuffle(1'b0);
    clear_hist();
    for (int i = 0; i < FULL; i++) do_deal();
    check_hist("hist_after_midshoe_shuffle");

    do_deal();
    do_deal();
    reset_abort(1'b0, 0);
    do_deal();
    reset_abort(1'b1, 5);
    do_deal();
    idle(2);
    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
